// File: rtl/arm_pipe_pkg.sv
// -----------------------------------------------------------------------------
// arm_pipe_pkg
//   Definitions shared by the pipeline front end: the instruction width, the
//   NOP encoding used for squashed fetches, the default reset PC and the
//   fetch FSM state type.
//   Ports: none (package).
// -----------------------------------------------------------------------------
package arm_pipe_pkg;

  localparam int unsigned INSTR_W          = 32;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  // Instructions are word aligned; any target with low bits set is a fault.
  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
//   Bundles the fetch stage's hazard/branch inputs, the instruction-memory
//   read port and the IF/ID-facing outputs.
//   Modports:
//     master - fetch_unit side (drives address, PC and IF/ID outputs)
//     slave  - environment side (hazard unit, ID stage, imem, IF/ID reg)
//   Parameter ADDR_W: instruction-memory byte-address width.
// -----------------------------------------------------------------------------
interface fetch_unit_if #(
  parameter int unsigned ADDR_W = 8
);
  import arm_pipe_pkg::*;

  logic                stall;
  logic                branch_taken;
  logic [31:0]         branch_target;
  logic [INSTR_W-1:0]  imem_instruction;
  logic [ADDR_W-1:0]   imem_address;
  logic [31:0]         pc_current;
  logic [31:0]         pc_plus_4;
  logic [INSTR_W-1:0]  if_instruction;
  logic [31:0]         if_pc;
  logic                if_valid;
  logic                if_id_enable;
  logic                fetch_fault;

  modport master (
    input  stall, branch_taken, branch_target, imem_instruction,
    output imem_address, pc_current, pc_plus_4, if_instruction, if_pc,
           if_valid, if_id_enable, fetch_fault
  );

  modport slave (
    output stall, branch_taken, branch_target, imem_instruction,
    input  imem_address, pc_current, pc_plus_4, if_instruction, if_pc,
           if_valid, if_id_enable, fetch_fault
  );

endinterface

// File: rtl/fetch_unit_perf_counters.sv
// -----------------------------------------------------------------------------
// fetch_perf_counters
//   Three 32-bit saturating event counters for the fetch stage. Only
//   instantiated when FETCH_PERF_CNT_EN is defined.
//   Ports:
//     clk, reset     - clock, asynchronous active-high reset (clears counts)
//     fetched_evt    - a valid word was handed to IF/ID this cycle
//     stall_evt      - the stage was stalled while running
//     flush_evt      - a taken redirect was performed
//     perf_fetched, perf_stalls, perf_flushes - counter values
// -----------------------------------------------------------------------------
module fetch_perf_counters (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetched_evt,
  input  logic        stall_evt,
  input  logic        flush_evt,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stalls,
  output logic [31:0] perf_flushes
);

  // Counters stick at all-ones rather than wrapping back to zero.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_stalls  <= '0;
      perf_flushes <= '0;
    end else begin
      if (fetched_evt) perf_fetched <= sat_inc(perf_fetched);
      if (stall_evt)   perf_stalls  <= sat_inc(perf_stalls);
      if (flush_evt)   perf_flushes <= sat_inc(perf_flushes);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch stage feeding if_id_reg. Owns the PC, drives the
//   instruction-memory address and presents word/PC/valid to IF/ID. Handles
//   load-use stalls, taken-branch redirects (one bubble, wrong-path fetch
//   squashed) and misaligned branch targets (sticky fault, PC frozen until
//   reset).
//   Ports:
//     clk    - system clock, rising edge
//     reset  - asynchronous, active-high
//     fif    - fetch_unit_if.master: stall, branch_taken, branch_target,
//              imem_instruction in; imem_address, pc_current, pc_plus_4,
//              if_instruction, if_pc, if_valid, if_id_enable, fetch_fault out
//     perf_fetched/perf_stalls/perf_flushes - only with FETCH_PERF_CNT_EN
//   Build option: `define FETCH_PERF_CNT_EN adds saturating perf counters.
// -----------------------------------------------------------------------------
module fetch_unit
  import arm_pipe_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  fetch_unit_if.master fif
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stalls,
  output logic [31:0] perf_flushes
`endif
);

  // Low bits forced to zero so the PC is word aligned even for an odd RESET_PC.
  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  fetch_state_t state;
  logic [31:0]  pc;
  logic         fault;

  logic         running;
  logic         redirect_req;
  logic         target_ok;
  logic         squash;
  logic [31:0]  pc_next_seq;

  assign running      = (state == RUN);
  // A stalled branch stays in ID and re-asserts, so stall masks it here.
  assign redirect_req = running && !fif.stall && fif.branch_taken;
  assign target_ok    = is_word_aligned(fif.branch_target);
  assign squash       = redirect_req;
  assign pc_next_seq  = pc + 32'd4;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= BOOT;
      pc    <= RESET_PC_ALIGNED;
      fault <= 1'b0;
    end else begin
      case (state)
        BOOT: state <= RUN;
        RUN: begin
          if (!fif.stall) begin
            if (fif.branch_taken) begin
              if (target_ok) begin
                pc <= fif.branch_target;
              end else begin
                state <= FAULT;
                fault <= 1'b1;
              end
            end else begin
              pc <= pc_next_seq;
            end
          end
        end
        FAULT: state <= FAULT;
        default: state <= BOOT;
      endcase
    end
  end

  // Word presentation is combinational so imem data, stall and branch_taken
  // reach IF/ID within the same cycle.
  always_comb begin
    fif.if_valid       = running && !squash;
    fif.if_instruction = fif.if_valid ? fif.imem_instruction : NOP_INSTR;
  end

  assign fif.imem_address = pc[ADDR_W-1:0];
  assign fif.pc_current   = pc;
  assign fif.pc_plus_4    = pc_next_seq;
  assign fif.if_pc        = pc;
  assign fif.if_id_enable = !fif.stall;
  assign fif.fetch_fault  = fault;

`ifdef FETCH_PERF_CNT_EN
  logic fetched_evt;
  logic stall_evt;
  logic flush_evt;

  assign fetched_evt = fif.if_valid && !fif.stall;
  assign stall_evt   = running && fif.stall;
  assign flush_evt   = redirect_req && target_ok;

  fetch_perf_counters u_perf (
    .clk          (clk),
    .reset        (reset),
    .fetched_evt  (fetched_evt),
    .stall_evt    (stall_evt),
    .flush_evt    (flush_evt),
    .perf_fetched (perf_fetched),
    .perf_stalls  (perf_stalls),
    .perf_flushes (perf_flushes)
  );
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Self-checking bench for fetch_unit: directed scenarios followed by random
//   stall/branch traffic, all compared against a behavioural model of the
//   fetch stage kept in this file.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  logic clk;
  logic reset;

  fetch_unit_if #(.ADDR_W(8)) bus ();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_stalls, perf_flushes;
`endif

  fetch_unit #(.ADDR_W(8), .RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .fif   (bus)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_stalls  (perf_stalls),
    .perf_flushes (perf_flushes)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: 64 words, wraps every 256 bytes.
  logic [31:0] mem [64];
  always_comb bus.imem_instruction = mem[bus.imem_address[7:2]];

  int unsigned n_checks = 0;
  int unsigned n_bad    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: mode 0 = just out of reset, 1 = fetching, 2 = faulted.
  int          m_mode;
  logic [31:0] m_pc;
  logic        m_fault;
  int unsigned m_fetched, m_stalls, m_flushes;

  function automatic logic exp_valid(input logic s, input logic b);
    return (m_mode == 1) && (s || !b);
  endfunction

  task automatic compare_outputs(input logic s, input logic b);
    logic v;
    v = exp_valid(s, b);
    check("if_valid",       {31'd0, bus.if_valid},     {31'd0, v});
    check("if_instruction", bus.if_instruction,        v ? mem[m_pc[7:2]] : 32'h0);
    check("pc_current",     bus.pc_current,            m_pc);
    check("if_pc",          bus.if_pc,                 m_pc);
    check("pc_plus_4",      bus.pc_plus_4,             m_pc + 32'd4);
    check("imem_address",   {24'd0, bus.imem_address}, {24'd0, m_pc[7:0]});
    check("if_id_enable",   {31'd0, bus.if_id_enable}, {31'd0, !s});
    check("fetch_fault",    {31'd0, bus.fetch_fault},  {31'd0, m_fault});
  endtask

  task automatic advance_model(input logic s, input logic b, input logic [31:0] t);
    if (m_mode == 1) begin
      if (exp_valid(s, b) && !s) m_fetched++;
      if (s) m_stalls++;
    end
    case (m_mode)
      0: m_mode = 1;
      1: begin
        if (!s && b) begin
          if (t % 4 == 0) begin
            m_pc = t;
            m_flushes++;
          end else begin
            m_mode  = 2;
            m_fault = 1'b1;
          end
        end else if (!s) begin
          m_pc = m_pc + 32'd4;
        end
      end
      default: ;
    endcase
  endtask

  task automatic step(input logic s, input logic b, input logic [31:0] t);
    @(negedge clk);
    bus.stall         = s;
    bus.branch_taken  = b;
    bus.branch_target = t;
    #1;
    compare_outputs(s, b);
    @(posedge clk);
    advance_model(s, b, t);
  endtask

  // Reset is asserted with stall and a branch pending; reset must win, and
  // the pending stall/branch must be ignored in the boot cycle too.
  task automatic do_reset();
    @(negedge clk);
    bus.stall         = 1'b1;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h0000_0044;
    reset = 1'b1;
    #1;
    check("rst_valid", {31'd0, bus.if_valid},    32'd0);
    check("rst_instr", bus.if_instruction,       32'h0);
    check("rst_pc",    bus.pc_current,           32'h0);
    check("rst_fault", {31'd0, bus.fetch_fault}, 32'd0);
    #2;
    reset     = 1'b0;
    m_mode    = 0;
    m_pc      = 32'h0;
    m_fault   = 1'b0;
    m_fetched = 0;
    m_stalls  = 0;
    m_flushes = 0;
    #1;
    compare_outputs(1'b1, 1'b1);
    @(posedge clk);
    advance_model(1'b1, 1'b1, 32'h0000_0044);
  endtask

  initial begin
    int fault_cycles;
    logic        rs, rb;
    logic [31:0] rt;

    reset             = 1'b1;
    bus.stall         = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = '0;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[0] = 32'h1111_0000;
    mem[1] = 32'h2222_0004;
    mem[2] = 32'h3333_0008;
    mem[3] = 32'h4444_000C;

    do_reset();

    // Sequential fetch 0, 4 then a two-cycle stall at 8.
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    // Redirect from 16 to 0x40.
    step(1'b0, 1'b1, 32'h0000_0040);
    step(1'b0, 1'b0, 32'h0);
    // Stall masks branch; releasing stall lets it redirect.
    step(1'b1, 1'b1, 32'h0000_0080);
    step(1'b1, 1'b1, 32'h0000_0080);
    step(1'b0, 1'b1, 32'h0000_0080);
    step(1'b0, 1'b0, 32'h0);
    // Memory-address wrap 252 -> 256, then 32-bit PC wrap.
    step(1'b0, 1'b1, 32'h0000_00FC);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    // Misaligned target: fault, then frozen bubbles whatever the inputs.
    step(1'b0, 1'b1, 32'h0000_0042);
    for (int i = 0; i < 10; i++)
      step(1'($urandom), 1'($urandom), $urandom);

`ifdef FETCH_PERF_CNT_EN
    @(negedge clk);
    check("perf_fetched", perf_fetched, m_fetched);
    check("perf_stalls",  perf_stalls,  m_stalls);
    check("perf_flushes", perf_flushes, m_flushes);
`endif

    do_reset();

    // Random traffic; misaligned targets are rare and recovered by reset.
    fault_cycles = 0;
    for (int i = 0; i < 400; i++) begin
      if (m_mode == 2 && fault_cycles > 4) begin
        do_reset();
        fault_cycles = 0;
      end
      rs = ($urandom % 4) == 0;
      rb = ($urandom % 6) == 0;
      rt = $urandom;
      if (($urandom % 10) != 0) rt[1:0] = 2'b00;
      if (m_mode == 2) fault_cycles++;
      step(rs, rb, rt);
    end

`ifdef FETCH_PERF_CNT_EN
    @(negedge clk);
    check("perf_fetched_rnd", perf_fetched, m_fetched);
    check("perf_stalls_rnd",  perf_stalls,  m_stalls);
    check("perf_flushes_rnd", perf_flushes, m_flushes);
`endif

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of if_id_reg. Replaces the bare program_counter + adder pair.
- Generates the instruction-memory address and presents the fetched word, its PC and a valid flag to IF/ID.
- Handles load-use stalls from ID, taken-branch redirects with squash of the wrong-path fetch, and misaligned-target faults.

Parameters:
- ADDR_W, 8, instruction-memory byte-address width driven to imem.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hazard unit: hold PC and IF/ID this cycle.
- branch_taken  in  1  ID stage: branch resolved taken this cycle.
- branch_target  in  32  ID stage: byte address of branch destination.
- imem_instruction  in  32  combinational read data from instruction_memory.
- imem_address  out  ADDR_W  equals pc_current[ADDR_W-1:0].
- pc_current  out  32  PC of the word being fetched.
- pc_plus_4  out  32  pc_current + 4, mod 2^32.
- if_instruction  out  32  word to IF/ID; 32'h0000_0000 (NOP) when squashed.
- if_pc  out  32  PC paired with if_instruction.
- if_valid  out  1  1 = real instruction, 0 = bubble.
- if_id_enable  out  1  drives IF/ID enable; equals ~stall.
- fetch_fault  out  1  sticky misaligned-target flag.

Behaviour:
- FSM states: BOOT, RUN, FAULT.
- Reset (async, any state, including mid-stall or mid-redirect) forces:
  - pc = RESET_PC, state = BOOT, fetch_fault = 0.
  - Outputs: if_valid = 0, if_instruction = NOP.
- BOOT: lasts exactly one cycle after reset deasserts. Outputs are a bubble and the PC is held. Next state is RUN.
- RUN, priority order evaluated each cycle:
  1. stall=1: PC holds; if_id_enable = 0; if_valid reflects the held word. branch_taken is ignored, because the branch stays in ID and re-asserts.
  2. branch_taken=1 with branch_target[1:0]==0: the current fetch is squashed combinationally (if_instruction = NOP, if_valid = 0). On the next edge pc <= branch_target. The target is fetched in the following cycle, so the penalty is exactly 1 bubble.
  3. branch_taken=1 with branch_target[1:0]!=0: squash as in case 2. Next state is FAULT, fetch_fault <= 1, and the PC is held.
  4. Otherwise: if_instruction = imem_instruction, if_valid = 1, if_pc = pc_current, and pc <= pc + 4.
- FAULT: emits a bubble every cycle, PC is frozen, fetch_fault stays 1. Only reset exits this state.
- Arithmetic:
  - The PC is 32-bit and wraps 32'hFFFF_FFFC -> 0.
  - imem_address truncates, so memory wraps every 2^ADDR_W bytes (255 -> 0 for the default).
  - pc_current[1:0] is always 00.
- Simultaneous stall and reset: reset wins. Simultaneous stall and branch in BOOT: both are ignored.
- Combinational paths: imem_instruction, stall and branch_taken reach outputs within the same cycle. The PC is the only state besides the FSM state and the fault flag.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds three 32-bit saturating counters, all cleared by reset:
  - perf_fetched counts cycles with if_valid=1 and stall=0.
  - perf_stalls counts cycles with stall=1 in RUN.
  - perf_flushes counts taken redirects.
  - Each counter is exposed as an output port of the same name.
- Undefined: no counters and no perf ports; functional behaviour is identical.

Decomposition:
- Shared package arm_pipe_pkg holds:
  - NOP_INSTR = 32'h0000_0000.
  - the fetch_state_t enum (BOOT, RUN, FAULT).
  - the default RESET_PC.
  - INSTR_W = 32.
- One sub-module, fetch_perf_counters, instantiated only under FETCH_PERF_CNT_EN.
- The FSM and PC stay in fetch_unit.

Test Plan:
- Reset held 3 time units, then released -> one BOOT bubble (if_valid=0, pc=0). Then pc steps 0,4,8,12 on successive edges and if_instruction matches preload words 0..3.
- Stall=1 for 2 cycles at pc=8 -> pc stays 8, if_id_enable=0 for 2 cycles, if_instruction is unchanged. Resumes at 12 afterwards.
- branch_taken=1 with target 32'h40 while pc=16 -> that cycle if_instruction=NOP and if_valid=0. Next cycle pc=0x40 and if_pc=0x40 with valid=1.
- branch_taken=1 with target 32'h42 -> fetch_fault=1 next cycle. Bubbles and a frozen PC persist for 10 cycles. Reset clears the fault and returns to BOOT.
- Stall and branch_taken both 1 -> PC holds and no redirect. Dropping stall with branch_taken still 1 -> redirect occurs.
- PC driven to 252 -> next imem_address=0 with pc=256. With FETCH_PERF_CNT_EN, counters match the counts of the previous scenarios.
